// File: rtl/ps2_digit_entry.sv
// ps2_digit_entry: PS/2 scancode sequencer that builds a multi-digit BCD entry.
// Tracks make / break (F0) / extended (E0) prefixes, appends digit make codes,
// handles backspace (66), enter (5A, also keypad E0 5A) and escape (76), and
// commits the entry to a holding register with a one-cycle strobe.
//
// Ports:
//   clk          rising-edge clock
//   areset       asynchronous active-high reset
//   code[7:0]    received scancode byte
//   code_valid   byte valid this cycle
//   digits       live entry, most recent digit in the low nibble
//   count        number of digits in the live entry
//   overflow     sticky: a digit was dropped because the entry was full
//   value        last committed entry
//   value_count  digit count of value
//   entry_valid  one-cycle commit strobe
//
// Build option: define PS2_TYPEMATIC_FILTER_EN to suppress keyboard auto-repeat
// via a held-key register.
module ps2_digit_entry #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic [7:0]                       code,
  input  logic                             code_valid,
  output logic [4*NDIGITS-1:0]             digits,
  output logic [$clog2(NDIGITS+1)-1:0]     count,
  output logic                             overflow,
  output logic [4*NDIGITS-1:0]             value,
  output logic [$clog2(NDIGITS+1)-1:0]     value_count,
  output logic                             entry_valid
);

  localparam int unsigned DW = 4 * NDIGITS;
  localparam int unsigned CW = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] digits_q, digits_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [DW-1:0] value_q, value_d;
  logic [CW-1:0] value_count_q, value_count_d;
  logic          entry_valid_q, entry_valid_d;

  logic       dig_ok;
  logic [3:0] dig_val;
  logic       filt_hit;
  logic       act_app, act_bs, act_ent, act_esc;

  // Digit make-code decode
  always_comb begin
    dig_ok  = 1'b1;
    dig_val = 4'd0;
    case (code)
      8'h45: dig_val = 4'd0;
      8'h16: dig_val = 4'd1;
      8'h1E: dig_val = 4'd2;
      8'h26: dig_val = 4'd3;
      8'h25: dig_val = 4'd4;
      8'h2E: dig_val = 4'd5;
      8'h36: dig_val = 4'd6;
      8'h3D: dig_val = 4'd7;
      8'h3E: dig_val = 4'd8;
      8'h46: dig_val = 4'd9;
      default: dig_ok = 1'b0;
    endcase
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0] held_q, held_d;

  // A repeated make of the held key is auto-repeat; held only ever holds
  // digit/66/5A codes or 00, so matching it can only suppress those.
  assign filt_hit = (code == held_q);

  // Remember last accepted key from IDLE; its break releases it
  always_comb begin
    held_d = held_q;
    if (code_valid) begin
      if (state_q == S_IDLE && !filt_hit &&
          (dig_ok || code == 8'h66 || code == 8'h5A)) begin
        held_d = code;
      end else if (state_q == S_BRK && code == held_q) begin
        held_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) held_q <= 8'h00;
    else        held_q <= held_d;
  end
`else
  assign filt_hit = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (code == 8'hF0)      state_d = S_BRK;
          else if (code == 8'hE0) state_d = S_EXT;
        end
        S_EXT: begin
          if (code == 8'hF0)      state_d = S_EXT_BRK;
          else if (code == 8'hE0) state_d = S_EXT;
          else                    state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: entry actions for the byte sampled this cycle
  always_comb begin
    act_app = 1'b0;
    act_bs  = 1'b0;
    act_ent = 1'b0;
    act_esc = 1'b0;
    if (code_valid) begin
      case (state_q)
        S_IDLE: begin
          if (!filt_hit) begin
            if (dig_ok)              act_app = 1'b1;
            else if (code == 8'h66)  act_bs  = 1'b1;
            else if (code == 8'h5A)  act_ent = 1'b1;
            else if (code == 8'h76)  act_esc = 1'b1;
          end
        end
        S_EXT:   act_ent = (code == 8'h5A);
        default: ;
      endcase
    end
  end

  // Entry datapath
  always_comb begin
    digits_d      = digits_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    value_d       = value_q;
    value_count_d = value_count_q;
    entry_valid_d = 1'b0;
    if (act_app) begin
      if (count_q < CW'(NDIGITS)) begin
        digits_d = (digits_q << 4) | DW'(dig_val);
        count_d  = count_q + CW'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end else if (act_bs) begin
      if (count_q != '0) begin
        digits_d = digits_q >> 4;
        count_d  = count_q - CW'(1);
      end
    end else if (act_ent) begin
      if (count_q != '0) begin
        value_d       = digits_q;
        value_count_d = count_q;
        entry_valid_d = 1'b1;
        digits_d      = '0;
        count_d       = '0;
        overflow_d    = 1'b0;
      end
    end else if (act_esc) begin
      digits_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      digits_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      value_q       <= '0;
      value_count_q <= '0;
      entry_valid_q <= 1'b0;
    end else begin
      digits_q      <= digits_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      value_q       <= value_d;
      value_count_q <= value_count_d;
      entry_valid_q <= entry_valid_d;
    end
  end

  assign digits      = digits_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign value       = value_q;
  assign value_count = value_count_q;
  assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Directed testbench for ps2_digit_entry (NDIGITS=4).
module tb_ps2_digit_entry;

  logic        clk;
  logic        areset;
  logic [7:0]  code;
  logic        code_valid;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        overflow;
  logic [15:0] value;
  logic [2:0]  value_count;
  logic        entry_valid;

  int checks = 0;
  int errors = 0;

  ps2_digit_entry #(.NDIGITS(4)) dut (
    .clk         (clk),
    .areset      (areset),
    .code        (code),
    .code_valid  (code_valid),
    .digits      (digits),
    .count       (count),
    .overflow    (overflow),
    .value       (value),
    .value_count (value_count),
    .entry_valid (entry_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the following negedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code       = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic press(input logic [7:0] b);
    send(b);
    send(8'hF0);
    send(b);
  endtask

  initial begin
    areset     = 1'b1;
    code       = 8'h00;
    code_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_value_count", 32'(value_count), 32'h0);
    chk("rst_entry_valid", 32'(entry_valid), 32'h0);
    areset = 1'b0;

    // Basic entry 1,2,3 then enter
    press(8'h16); press(8'h1E); press(8'h26);
    chk("t1_digits", 32'(digits), 32'h0123);
    chk("t1_count", 32'(count), 32'h3);
    send(8'h5A);
    chk("t1_strobe", 32'(entry_valid), 32'h1);
    chk("t1_value", 32'(value), 32'h0123);
    chk("t1_value_count", 32'(value_count), 32'h3);
    chk("t1_digits_clr", 32'(digits), 32'h0);
    chk("t1_count_clr", 32'(count), 32'h0);
    @(negedge clk);
    chk("t1_strobe_off", 32'(entry_valid), 32'h0);
    send(8'hF0); send(8'h5A);

    // Overflow: fifth digit dropped
    press(8'h16); press(8'h1E); press(8'h26); press(8'h25);
    chk("t2_ovf_pre", 32'(overflow), 32'h0);
    press(8'h2E);
    chk("t2_digits", 32'(digits), 32'h1234);
    chk("t2_count", 32'(count), 32'h4);
    chk("t2_overflow", 32'(overflow), 32'h1);
    send(8'h5A);
    chk("t2_strobe", 32'(entry_valid), 32'h1);
    chk("t2_value", 32'(value), 32'h1234);
    chk("t2_value_count", 32'(value_count), 32'h4);
    chk("t2_ovf_clr", 32'(overflow), 32'h0);
    send(8'hF0); send(8'h5A);

    // Backspace
    press(8'h3D); press(8'h3E);
    chk("t3_digits78", 32'(digits), 32'h0078);
    press(8'h66);
    chk("t3_bs_digits", 32'(digits), 32'h0007);
    chk("t3_bs_count", 32'(count), 32'h1);
    send(8'h5A);
    chk("t3_value", 32'(value), 32'h0007);
    chk("t3_value_count", 32'(value_count), 32'h1);
    send(8'hF0); send(8'h5A);
    press(8'h66);
    chk("t3_bs_empty_digits", 32'(digits), 32'h0);
    chk("t3_bs_empty_count", 32'(count), 32'h0);
    send(8'h5A);
    chk("t3_enter_empty_strobe", 32'(entry_valid), 32'h0);
    chk("t3_enter_empty_value", 32'(value), 32'h0007);
    send(8'hF0); send(8'h5A);

    // Extended codes
    press(8'h45); press(8'h46);
    chk("t4_digits", 32'(digits), 32'h0009);
    send(8'hE0); send(8'hF0); send(8'h5A);
    chk("t4_extbrk_strobe", 32'(entry_valid), 32'h0);
    chk("t4_extbrk_count", 32'(count), 32'h2);
    send(8'hE0); send(8'h5A);
    chk("t4_kp_strobe", 32'(entry_valid), 32'h1);
    chk("t4_kp_value", 32'(value), 32'h0009);
    chk("t4_kp_value_count", 32'(value_count), 32'h2);
    send(8'hE0); send(8'h75);
    chk("t4_ext_ign_count", 32'(count), 32'h0);
    send(8'h16);
    chk("t4_idle_digits", 32'(digits), 32'h0001);
    send(8'hF0); send(8'h16);

    // Break prefix persists across idle cycles
    send(8'hF0);
    repeat (5) @(negedge clk);
    send(8'h1E);
    chk("t5_prefix_hold_count", 32'(count), 32'h1);

    // Escape clears live entry, keeps value; clears overflow
    press(8'h1E); press(8'h26); press(8'h25); press(8'h2E);
    chk("t5_esc_pre_ovf", 32'(overflow), 32'h1);
    send(8'h76);
    chk("t5_esc_digits", 32'(digits), 32'h0);
    chk("t5_esc_count", 32'(count), 32'h0);
    chk("t5_esc_overflow", 32'(overflow), 32'h0);
    chk("t5_esc_value", 32'(value), 32'h0009);
    send(8'hF0); send(8'h76);

    // Typematic repeat stream
    send(8'h16); send(8'h16); send(8'h16);
    send(8'hF0); send(8'h16);
    send(8'h16);
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("t6_rep_count", 32'(count), 32'h2);
    chk("t6_rep_digits", 32'(digits), 32'h0011);
`else
    chk("t6_rep_count", 32'(count), 32'h4);
    chk("t6_rep_digits", 32'(digits), 32'h1111);
`endif

    // Reset mid-sequence after a break prefix
    send(8'hF0);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    chk("t7_rst_digits", 32'(digits), 32'h0);
    chk("t7_rst_count", 32'(count), 32'h0);
    chk("t7_rst_value", 32'(value), 32'h0);
    chk("t7_rst_value_count", 32'(value_count), 32'h0);
    chk("t7_rst_overflow", 32'(overflow), 32'h0);
    chk("t7_rst_strobe", 32'(entry_valid), 32'h0);
    areset = 1'b0;
    send(8'h16);
    chk("t7_post_digits", 32'(digits), 32'h0001);
    chk("t7_post_count", 32'(count), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_digit_entry.md
# ps2_digit_entry

Sequencing controller for the PS/2 scancode-to-digit decode path. Consumes the raw keyboard byte stream one byte per `code_valid` strobe and tracks make, break (0xF0) and extended (0xE0) prefixes. Builds a multi-digit BCD entry from digit make codes 0–9 and supports backspace, escape and enter. On enter it commits the entry to a holding register for downstream logic, with a one-cycle strobe.

## Interface
- `NDIGITS`, default 4: BCD digit capacity of the entry buffer (≥1).
- `clk`  in  1  rising-edge clock.
- `areset`  in  1  asynchronous, active-high reset.
- `code`  in  8  received scancode byte.
- `code_valid`  in  1  `code` is valid this cycle; one byte is consumed per high cycle.
- `digits`  out  4*NDIGITS  live entry; most recent digit in the low nibble; reset 0.
- `count`  out  $clog2(NDIGITS+1)  number of digits in the live entry; reset 0.
- `overflow`  out  1  sticky flag: a digit was dropped because the buffer was full; reset 0.
- `value`  out  4*NDIGITS  last committed entry; reset 0.
- `value_count`  out  $clog2(NDIGITS+1)  digit count of `value`; reset 0.
- `entry_valid`  out  1  single-cycle commit strobe; reset 0.

## Operation
- Digit map:
  - 45→0, 16→1, 1E→2, 26→3, 25→4, 2E→5, 36→6, 3D→7, 3E→8, 46→9.
  - Command codes: 66 = backspace, 5A = enter, 76 = escape.
- FSM states are IDLE, EXT, BRK and EXT_BRK. Reset state is IDLE.
- State transitions are evaluated only on cycles where `code_valid`=1.
- IDLE:
  - F0 goes to BRK.
  - E0 goes to EXT.
  - A digit make code appends that digit.
  - 66 performs backspace, 5A performs enter, 76 performs escape.
  - Any other byte is ignored and the state stays IDLE.
- BRK: any byte returns to IDLE. The byte is consumed as a break code and has no entry effect.
- EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT.
  - 5A (keypad enter) performs enter and returns to IDLE.
  - Any other byte is ignored and returns to IDLE.
- EXT_BRK: any byte returns to IDLE with no entry effect.
- Append:
  - If `count` < NDIGITS: `digits` ← (`digits` << 4) | d and `count`+1.
  - Otherwise the digit is dropped, `overflow` ← 1 and `digits`/`count` are unchanged.
- Backspace:
  - If `count` > 0: `digits` ← `digits` >> 4 (top nibble becomes 0) and `count`−1.
  - If `count` = 0: no-op.
  - `overflow` is unchanged.
- Enter:
  - If `count` > 0: `value` ← `digits`, `value_count` ← `count`, `entry_valid` ← 1, then `digits`, `count` and `overflow` are cleared.
  - If `count` = 0: no effect and no strobe.
- Escape: clears `digits`, `count` and `overflow`. `value` is unaffected.
- `value` and `value_count` hold until the next successful commit.

## Timing
- All outputs are registered and update on the edge that samples `code_valid`=1. Latency is 1 cycle from byte to effect.
- `entry_valid` is high for exactly the one cycle after the enter byte is sampled, then returns to 0. There is no backpressure.
- `code_valid`=0: all state holds. Back-to-back bytes on consecutive cycles are fully supported.
- Prefix state persists indefinitely across idle cycles until the next byte arrives.
- Reset mid-sequence (for example after F0): FSM returns to IDLE and every output returns to its reset value. The next byte is treated as a fresh make code.
- `areset` asserted together with `code_valid`: reset wins and the byte is lost.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - A `held` register (reset 00) records the last code accepted from IDLE as digit, backspace or enter.
  - A make code from IDLE equal to `held` is ignored, which suppresses keyboard auto-repeat.
  - A break sequence (F0 x) whose x equals `held` clears `held` to 00.
  - Keypad enter (E0 5A) is never filtered.
- `PS2_TYPEMATIC_FILTER_EN` undefined: no `held` register is built, and every make code is acted on, including auto-repeats.

## Test plan
- NDIGITS=4, bytes 16,F0,16,1E,F0,1E,26,F0,26,5A → `value`=16'h0123, `value_count`=3, `entry_valid` high 1 cycle, then `digits`=0, `count`=0.
- Digits 1,2,3,4,5 (with breaks), then 5A → fifth digit dropped, `overflow`=1 before enter, `value`=16'h1234, `overflow` cleared after commit.
- Digits 7,8, then 66, then 5A → `value`=16'h0007, `value_count`=1. 66 with `count`=0 → no change. 5A with `count`=0 → no strobe.
- E0,F0,5A → no commit. E0,5A with `count`=2 → commit. E0,75 → ignored, FSM back in IDLE.
- Macro defined: 16,16,16,F0,16,16 → `count`=2 (one digit per press). Macro undefined: same stream → `count`=4.
- F0, then `areset` pulse, then 16 → `digits`=16'h0001, `count`=1. All outputs read 0 during reset.
